// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;
    localparam logic [3:0]  WSTRB_WORD    = 4'hF;

endpackage

// File: rtl/dmem_watchdog.sv
// Cycle counter for an outstanding bus access; o_expired flags the last
// permitted cycle so the controller can abandon the access.
module dmem_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_active,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= '0;
        end else if (i_active && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = i_active && (r_count == LIMIT);

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory controller: one bus transaction per LW/SW, then a
// dmem_continue pulse. Optional watchdog enabled by DMEM_TIMEOUT_EN.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_access_m,
    input  logic              mem_write_m,
    input  logic [31:0]       pc_m,
    input  logic [ADDR_W-1:0] alu_out_m,
    input  logic [DATA_W-1:0] write_data_m,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic              dreq_write,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [DATA_W-1:0] dreq_wdata,
    output logic [3:0]        dreq_wstrb,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_rdata,
    output logic [DATA_W-1:0] read_data_m,
    output logic              dmem_continue,
    output logic              busy,
    output logic              dmem_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    dmem_state_t       r_state;
    dmem_state_t       w_state_next;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [31:0]       r_pc;
    logic [31:0]       r_last_pc;
    logic              r_served;
    logic              w_accept;
    logic              w_active;
    logic              w_handshake;
    logic              w_resp_done;
    logic              w_timeout;

    // An instruction is skipped when it is the one just served and the
    // pipeline has not yet moved on.
    assign w_accept    = (r_state == IDLE) && mem_access_m
                         && !(r_served && (pc_m == r_last_pc));
    assign w_active    = (r_state == REQ) || (r_state == WAIT);
    assign dreq_valid  = (r_state == REQ) && !w_timeout;
    assign w_handshake = dreq_valid && dreq_ready;
    assign w_resp_done = dresp_valid && (w_handshake || (r_state == WAIT));

`ifdef DMEM_TIMEOUT_EN
    logic r_err;

    dmem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst),
        .i_start  (w_accept),
        .i_active (w_active),
        .o_expired(w_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_resp_done) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign dmem_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign dmem_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = REQ;
            REQ: begin
                if (w_resp_done)      w_state_next = DONE;
                else if (w_handshake) w_state_next = WAIT;
                else if (w_timeout)   w_state_next = DONE;
            end
            WAIT: if (w_resp_done || w_timeout) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_pc      <= '0;
            r_rdata   <= '0;
            r_last_pc <= '0;
            r_served  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= mem_write_m;
                r_addr  <= alu_out_m;
                r_wdata <= write_data_m;
                r_pc    <= pc_m;
            end
            // A timed-out load still returns a recognisable value to writeback.
            if (w_resp_done && !r_write) begin
                r_rdata <= dresp_rdata;
            end else if (w_timeout && !r_write) begin
                r_rdata <= DATA_W'(DMEM_ERR_DATA);
            end
            if (r_state == DONE) begin
                r_served  <= 1'b1;
                r_last_pc <= r_pc;
            end else if ((r_state == IDLE) && !mem_access_m) begin
                r_served <= 1'b0;
            end
        end
    end

    assign dreq_write    = r_write;
    assign dreq_addr     = r_addr;
    assign dreq_wdata    = r_wdata;
    assign dreq_wstrb    = r_write ? WSTRB_WORD : 4'h0;
    assign read_data_m   = r_rdata;
    assign dmem_continue = (r_state == DONE);
    assign busy          = w_active;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: transaction-level model plus
// directed LW/SW, stall, back-to-back, reset and (DMEM_TIMEOUT_EN) timeout cases.
module tb_dmem_access_ctrl;

    localparam int TB_TIMEOUT = 8;
`ifdef DMEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_access_m = 1'b0;
    logic        mem_write_m = 1'b0;
    logic [31:0] pc_m = '0;
    logic [31:0] alu_out_m = '0;
    logic [31:0] write_data_m = '0;
    logic        dreq_valid;
    logic        dreq_ready = 1'b0;
    logic        dreq_write;
    logic [31:0] dreq_addr;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        dresp_valid = 1'b0;
    logic [31:0] dresp_rdata = '0;
    logic [31:0] read_data_m;
    logic        dmem_continue;
    logic        busy;
    logic        dmem_err;

    dmem_access_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_access_m(mem_access_m), .mem_write_m(mem_write_m),
        .pc_m(pc_m), .alu_out_m(alu_out_m), .write_data_m(write_data_m),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_write(dreq_write),
        .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .read_data_m(read_data_m), .dmem_continue(dmem_continue),
        .busy(busy), .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_in_flight, m_granted, m_finishing, m_served, m_err;
    bit          m_write;
    logic [31:0] m_addr, m_wdata, m_pc, m_last_pc, m_rdata;
    int          m_age;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_in_flight = 0; m_granted = 0; m_finishing = 0; m_served = 0; m_err = 0;
            m_write = 0; m_addr = '0; m_wdata = '0; m_pc = '0; m_last_pc = '0;
            m_rdata = '0; m_age = 0;
        end else if (m_finishing) begin
            m_finishing = 0;
            m_served    = 1;
            m_last_pc   = m_pc;
        end else if (!m_in_flight) begin
            if (mem_access_m && !(m_served && pc_m == m_last_pc)) begin
                m_write = mem_write_m; m_addr = alu_out_m; m_wdata = write_data_m;
                m_pc = pc_m; m_in_flight = 1; m_granted = 0; m_age = 0;
            end else if (!mem_access_m) begin
                m_served = 0;
            end
        end else begin
            bit timed, hs;
            timed = TO_EN && (m_age == TB_TIMEOUT - 1);
            hs    = !m_granted && !timed && dreq_ready;
            if (dresp_valid && (m_granted || hs)) begin
                if (!m_write) m_rdata = dresp_rdata;
                m_err = 0; m_in_flight = 0; m_finishing = 1;
            end else if (timed) begin
                if (!m_write) m_rdata = 32'hDEADBEEF;
                m_err = 1; m_in_flight = 0; m_finishing = 1;
            end else begin
                if (hs) m_granted = 1;
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (checking && rst) begin
            bit exp_valid;
            exp_valid = m_in_flight && !m_granted && !(TO_EN && m_age == TB_TIMEOUT - 1);
            check("dreq_valid", {31'd0, dreq_valid}, {31'd0, exp_valid});
            check("busy", {31'd0, busy}, {31'd0, m_in_flight});
            check("dmem_continue", {31'd0, dmem_continue}, {31'd0, m_finishing});
            check("read_data_m", read_data_m, m_rdata);
            check("dmem_err", {31'd0, dmem_err}, {31'd0, m_err});
            if (exp_valid) begin
                check("dreq_addr", dreq_addr, m_addr);
                check("dreq_wdata", dreq_wdata, m_wdata);
                check("dreq_write", {31'd0, dreq_write}, {31'd0, m_write});
                check("dreq_wstrb", {28'd0, dreq_wstrb}, m_write ? 32'hF : 32'h0);
            end
        end
    end

    // ---------------- bus responder ----------------
    int          stall_cfg = 0;
    int          resp_delay = 0;    // -1: respond in the accept cycle
    bit          resp_en = 1'b1;
    logic [31:0] resp_data = '0;
    int          stall_left = -1;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    bit          inject = 1'b0;

    always @(negedge clk) begin
        dresp_valid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                dresp_valid = 1'b1; dresp_rdata = resp_data; pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (inject) begin
            dresp_valid = 1'b1; dresp_rdata = 32'h77778888; inject = 1'b0;
        end
        dreq_ready = 1'b0;
        if (dreq_valid === 1'b1) begin
            if (stall_left < 0) stall_left = stall_cfg;
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                dreq_ready = 1'b1;
                stall_left = -1;
                if (resp_en) begin
                    if (resp_delay < 0) begin
                        dresp_valid = 1'b1; dresp_rdata = resp_data;
                    end else begin
                        pend = 1'b1; pend_cnt = resp_delay;
                    end
                end
            end
        end
    end

    // ---------------- activity counters ----------------
    int n_valid_cyc = 0, n_txn = 0, n_cont = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (dreq_valid) n_valid_cyc <= n_valid_cyc + 1;
            if (dreq_valid && dreq_ready) n_txn <= n_txn + 1;
            if (dmem_continue) n_cont <= n_cont + 1;
        end
    end

    task automatic drive(input bit acc, input bit wr, input logic [31:0] pc,
                         input logic [31:0] addr, input logic [31:0] data);
        mem_access_m = acc; mem_write_m = wr; pc_m = pc; alu_out_m = addr; write_data_m = data;
    endtask

    task automatic wait_cont(input int budget, output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (dmem_continue === 1'b1) break;
            if (lat >= budget) begin
                n_checks++; n_fail++;
                $display("FAIL wait_continue: no pulse within %0d cycles", budget);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, v0, t0, c0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset dreq_valid", {31'd0, dreq_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset read_data_m", read_data_m, 32'd0);
        check("reset dmem_err", {31'd0, dmem_err}, 32'd0);
        checking = 1'b1;

        // LW, one-cycle response after accept
        @(negedge clk);
        v0 = n_valid_cyc; t0 = n_txn; c0 = n_cont;
        stall_cfg = 0; resp_delay = 0; resp_en = 1; resp_data = 32'h12345678;
        drive(1, 0, 32'h40, 32'h100, 32'h0);
        wait_cont(20, lat);
        $display("LW  pc=40 addr=100 latency=%0d rdata=%h", lat, read_data_m);
        check("lw latency", lat, 32'd3);
        check("lw read_data", read_data_m, 32'h12345678);
        drive(0, 0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("lw valid cycles", n_valid_cyc - v0, 32'd1);
        check("lw txn count", n_txn - t0, 32'd1);
        check("lw continue count", n_cont - c0, 32'd1);

        // SW held static for 10 cycles with 3 ready-low cycles
        v0 = n_valid_cyc; t0 = n_txn; c0 = n_cont;
        stall_cfg = 3;
        drive(1, 1, 32'h44, 32'h104, 32'hCAFEF00D);
        repeat (10) @(negedge clk);
        $display("SW  pc=44 addr=104 wdata=CAFEF00D txns=%0d continues=%0d", n_txn - t0, n_cont - c0);
        check("sw valid cycles", n_valid_cyc - v0, 32'd4);
        check("sw txn count", n_txn - t0, 32'd1);
        check("sw continue count", n_cont - c0, 32'd1);
        check("sw keeps read_data", read_data_m, 32'h12345678);
        drive(0, 0, 32'h0, 32'h0, 32'h0);
        stall_cfg = 0;
        @(negedge clk);

        // back-to-back LW (response shortcut) then SW
        t0 = n_txn; c0 = n_cont;
        resp_delay = -1; resp_data = 32'hA5A55A5A;
        drive(1, 0, 32'h48, 32'h108, 32'h0);
        wait_cont(20, lat);
        $display("LW  pc=48 addr=108 latency=%0d rdata=%h", lat, read_data_m);
        check("b2b lw latency", lat, 32'd2);
        resp_delay = 0;
        drive(1, 1, 32'h4C, 32'h10C, 32'h0BADCAFE);
        wait_cont(20, lat);
        $display("SW  pc=4C addr=10C latency=%0d", lat);
        check("b2b sw latency", lat, 32'd4);
        drive(0, 0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("b2b read_data", read_data_m, 32'hA5A55A5A);
        check("b2b txn count", n_txn - t0, 32'd2);
        check("b2b continue count", n_cont - c0, 32'd2);

        // reset while waiting for a response
        c0 = n_cont;
        resp_en = 0;
        drive(1, 0, 32'h50, 32'h110, 32'h0);
        repeat (2) @(negedge clk);
        check("pre-reset in wait", {31'd0, busy & ~dreq_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        $display("RST asserted in WAIT: busy=%b valid=%b rdata=%h", busy, dreq_valid, read_data_m);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst dreq_valid", {31'd0, dreq_valid}, 32'd0);
        check("rst dmem_continue", {31'd0, dmem_continue}, 32'd0);
        check("rst read_data", read_data_m, 32'd0);
        check("rst dreq_addr", dreq_addr, 32'd0);
        check("rst dreq_wstrb", {28'd0, dreq_wstrb}, 32'd0);
        drive(0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        inject = 1'b1;
        repeat (5) @(negedge clk);
        $display("RST late response injected: continues=%0d rdata=%h", n_cont - c0, read_data_m);
        check("late resp continue count", n_cont - c0, 32'd0);
        check("late resp read_data", read_data_m, 32'd0);
        check("late resp busy", {31'd0, busy}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
        // LW that never gets a response
        resp_en = 0;
        drive(1, 0, 32'h60, 32'h120, 32'h0);
        wait_cont(40, lat);
        $display("TMO pc=60 latency=%0d rdata=%h err=%b", lat, read_data_m, dmem_err);
        check("timeout latency", lat, 32'd9);
        check("timeout read_data", read_data_m, 32'hDEADBEEF);
        check("timeout dmem_err", {31'd0, dmem_err}, 32'd1);
        drive(0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        resp_en = 1; resp_delay = 0; resp_data = 32'h11112222;
        drive(1, 0, 32'h64, 32'h124, 32'h0);
        wait_cont(20, lat);
        $display("LW  pc=64 after timeout: rdata=%h err=%b", read_data_m, dmem_err);
        check("recovery dmem_err", {31'd0, dmem_err}, 32'd0);
        check("recovery read_data", read_data_m, 32'h11112222);
        drive(0, 0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
`endif

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
